// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer: encodes one instruction field set into a 32-bit word
// and writes it little-endian, one byte per cycle, into a byte-wide memory port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous restart of pointer, flags and FSM
//   in_valid/in_ready : field-set handshake (in_ready is combinational)
//   in_op, in_rd, in_rs1, in_rs2, in_imm : instruction fields
//   mem_we/mem_addr/mem_wdata : registered byte write port
//   busy              : a word write is in progress
//   err, wrap         : sticky illegal-op and pointer-wrap flags
module instr_encoder_writer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              err,
  output logic              wrap
);

  localparam int unsigned WORD_W = 32;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state;
  logic [1:0]          bc;
  logic [ADDR_W-1:0]   ptr;
  logic [WORD_W-1:0]   word;

  logic [6:0]          opcode_c;
  logic [WORD_W-1:0]   enc_word_c;
  logic                legal_c;
  logic                accept_c;
  logic [1:0]          bc_inc_c;
  logic [ADDR_W-1:0]   ptr_plus4_c;
  logic [ADDR_W-1:0]   ptr_last_c;

  // Instruction encoder
  always_comb begin
    opcode_c   = {1'b0, in_op, 2'b11};
    legal_c    = (in_op != 4'd10) && (in_op != 4'd15);
    enc_word_c = '0;
    case (in_op)
      4'd0, 4'd14:
        enc_word_c = {in_imm, in_rs1, 3'b000, in_rd, opcode_c};
      4'd1, 4'd11, 4'd12:
        enc_word_c = {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], opcode_c};
      4'd13:
        enc_word_c = {in_imm, 13'b0, opcode_c};
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
        enc_word_c = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, opcode_c};
      default:
        enc_word_c = '0;
    endcase
  end

  // A new word may be taken while idle or while the last byte is on the bus
  assign in_ready    = !clear && ((state == IDLE) || (bc == 2'd3));
  assign accept_c    = in_valid && in_ready;
  assign busy        = (state == WRITE);
  assign bc_inc_c    = bc + 2'd1;
  assign ptr_plus4_c = ptr + ADDR_W'(4);
  assign ptr_last_c  = {{(ADDR_W-2){1'b1}}, 2'b00};

  // FSM, pointer, flags and registered byte port; outputs are loaded one
  // edge ahead so byte bc is on the bus while bc holds that value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bc        <= 2'd0;
      ptr       <= '0;
      word      <= '0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else if (clear) begin
      state  <= IDLE;
      bc     <= 2'd0;
      ptr    <= '0;
      err    <= 1'b0;
      wrap   <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (legal_c) begin
              state     <= WRITE;
              bc        <= 2'd0;
              word      <= enc_word_c;
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= enc_word_c[7:0];
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bc != 2'd3) begin
            bc        <= bc_inc_c;
            mem_addr  <= ptr + ADDR_W'(bc_inc_c);
            mem_wdata <= word[{bc_inc_c, 3'b000} +: 8];
          end else begin
            ptr <= ptr_plus4_c;
            if (ptr == ptr_last_c) begin
              wrap <= 1'b1;
            end
            bc <= 2'd0;
            if (accept_c && legal_c) begin
              word      <= enc_word_c;
              mem_addr  <= ptr_plus4_c;
              mem_wdata <= enc_word_c[7:0];
            end else begin
              state  <= IDLE;
              mem_we <= 1'b0;
              if (accept_c) begin
                err <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Scoreboard bench for instr_encoder_writer (ADDR_W=4 so pointer wrap is reachable).
module tb_instr_encoder_writer;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [11:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy, err, wrap;

  instr_encoder_writer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .err(err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [AW-1:0] ptr_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every byte write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%02h at cycle %0d", mem_addr, mem_wdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL byte_write: got addr 0x%0h data 0x%02h cycle %0d expected addr 0x%0h data 0x%02h cycle %0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Issue one field set; on acceptance queue its four expected bytes
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm,
                      input bit legal, input logic [31:0] exp_word);
    bit got = 1'b0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (legal) begin
      for (int i = 0; i < 4; i++)
        exp_q.push_back('{addr: ptr_m + AW'(i), data: exp_word[8*i +: 8], cyc: cyc + i});
      ptr_m = ptr_m + AW'(4);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d bytes still pending, busy=%0b", exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ptr_m = '0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD rd=1 rs1=2 rs2=3
    send(4'd2, 5'd1, 5'd2, 5'd3, 12'h000, 1'b1, 32'h0031008B);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_in_ready_bc0", 32'(in_ready), 32'd0);
    drain();

    // LD then ST back to back
    do_clear();
    send(4'd0, 5'd5, 5'd0, 5'd0, 12'h004, 1'b1, 32'h00400283);
    send(4'd1, 5'd0, 5'd1, 5'd2, 12'h010, 1'b1, 32'h00208807);
    drain();

    // Illegal op: no write, err set, pointer untouched; clear drops err
    do_clear();
    send(4'd2, 5'd1, 5'd2, 5'd3, 12'h000, 1'b1, 32'h0031008B);
    send(4'd10, 5'd1, 5'd1, 5'd1, 12'h123, 1'b0, 32'h0);
    chk("illegal_err", 32'(err), 32'd1);
    drain();
    send(4'd15, 5'd1, 5'd1, 5'd1, 12'h123, 1'b0, 32'h0);
    chk("illegal15_busy", 32'(busy), 32'd0);
    send(4'd13, 5'd0, 5'd0, 5'd0, 12'hABC, 1'b1, 32'hABC00037);
    drain();
    chk("err_sticky", 32'(err), 32'd1);
    do_clear();
    chk("clear_err", 32'(err), 32'd0);

    // Five words with a 16-byte space: wrap after the fourth
    send(4'd14, 5'd31, 5'd0, 5'd0, 12'hFFF, 1'b1, 32'hFFF00FBB);
    send(4'd3,  5'd2,  5'd3, 5'd4, 12'h000, 1'b1, 32'h0041810F);
    send(4'd11, 5'd31, 5'd5, 5'd6, 12'hFFF, 1'b1, 32'hFE628FAF);
    drain();
    chk("wrap_before", 32'(wrap), 32'd0);
    send(4'd9,  5'd7,  5'd8, 5'd9, 12'h000, 1'b1, 32'h009403A7);
    drain();
    chk("wrap_after", 32'(wrap), 32'd1);
    send(4'd12, 5'd0,  5'd0, 5'd1, 12'h021, 1'b1, 32'h021000B3);
    drain();
    chk("wrap_sticky", 32'(wrap), 32'd1);
    do_clear();
    chk("clear_wrap", 32'(wrap), 32'd0);

    // Asynchronous reset during byte 2
    send(4'd2, 5'd1, 5'd2, 5'd3, 12'h000, 1'b1, 32'h0031008B);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_we", 32'(mem_we), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_lost_bytes", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_m = '0;
    send(4'd4, 5'd3, 5'd4, 5'd0, 12'h000, 1'b1, 32'h00020193);
    drain();

    // Clear during byte 1 while a new field set is offered
    do_clear();
    send(4'd2, 5'd1, 5'd2, 5'd3, 12'h000, 1'b1, 32'h0031008B);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd8; in_rd = 5'd1; in_rs1 = 5'd1; in_rs2 = 5'd1; in_imm = 12'h0;
    clear = 1'b1;
    #1;
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_mem_we", 32'(mem_we), 32'd0);
    chk("clear_abandoned_bytes", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    ptr_m = '0;
    send(4'd8, 5'd4, 5'd5, 5'd6, 12'h000, 1'b1, 32'h00628223);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
